// File: rtl/gray_stream_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : gray_stream_decoder_if
// Purpose  : Bundles the Gray-code input stream, the decoded output stream and
//            the error-monitor signals of gray_stream_decoder.
// Ports    : in_valid/in_ready/in_gray          - upstream Gray stream
//            out_valid/out_ready/out_binary,
//            out_step_err/out_wrap              - decoded sample stream
//            err_count/clear_errs               - step-error monitor
// Modports : master - the surrounding logic (drives inputs, reads results)
//            slave  - the decoder itself
// Revision : 1.0 - initial release
// ============================================================================
interface gray_stream_decoder_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_gray;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_binary;
  logic                 out_step_err;
  logic                 out_wrap;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 clear_errs;

  modport master (
    output in_valid, in_gray, out_ready, clear_errs,
    input  in_ready, out_valid, out_binary, out_step_err, out_wrap, err_count
  );

  modport slave (
    input  in_valid, in_gray, out_ready, clear_errs,
    output in_ready, out_valid, out_binary, out_step_err, out_wrap, err_count
  );
endinterface
`default_nettype wire

// File: rtl/gray_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : gray_stream_decoder
// Purpose  : Converts a valid/ready stream of Gray codes back to binary via a
//            one-entry registered output stage, and monitors that successive
//            accepted codes differ in exactly one bit (saturating error count).
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - gray_stream_decoder_if.slave (input stream, output
//                    stream, err_count, clear_errs)
// Revision : 1.0 - initial release
// ============================================================================
module gray_stream_decoder #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input wire logic                 clk,
  input wire logic                 rst_n,
  gray_stream_decoder_if.slave     bus
);

  // Gray code of binary all-ones: the predecessor of 0 in a wrapping count.
  localparam logic [WIDTH-1:0] c_wrap_prev = {1'b1, {(WIDTH-1){1'b0}}};

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_binary;
  logic                 r_out_step_err;
  logic                 r_out_wrap;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [WIDTH-1:0]     r_prev_gray;
  logic                 r_has_prev;

  logic                 w_in_ready;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_bin;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_one_bit;
  logic                 w_checked;
  logic                 w_step_err;
  logic                 w_wrap;
  logic                 w_err_sat;

  // The stage may refill while it drains, so a full stage with out_ready
  // still accepts and throughput stays at one sample per cycle.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin            = '0;
    w_bin[WIDTH-1]   = bus.in_gray[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ bus.in_gray[i];
    end
  end

  // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves 0.
  assign w_diff    = bus.in_gray ^ r_prev_gray;
  assign w_one_bit = (w_diff != '0) &&
                     ((w_diff & (w_diff - WIDTH'(1))) == '0);

  // A clear in the same cycle makes the incoming sample the new first one.
  assign w_checked  = r_has_prev && !bus.clear_errs;
  assign w_step_err = w_checked && !w_one_bit;
  assign w_wrap     = w_checked && (bus.in_gray == '0) &&
                      (r_prev_gray == c_wrap_prev);
  assign w_err_sat  = &r_err_count;

  // Output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_binary   <= '0;
      r_out_step_err <= 1'b0;
      r_out_wrap     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_binary   <= w_bin;
      r_out_step_err <= w_step_err;
      r_out_wrap     <= w_wrap;
    end else if (bus.out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  // Sequence history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gray <= '0;
      r_has_prev  <= 1'b0;
    end else if (w_accept) begin
      r_prev_gray <= bus.in_gray;
      r_has_prev  <= 1'b1;
    end else if (bus.clear_errs) begin
      r_has_prev  <= 1'b0;
    end
  end

  // Saturating step-error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (bus.clear_errs) begin
      r_err_count <= '0;
    end else if (w_accept && w_step_err && !w_err_sat) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_binary   = r_out_binary;
  assign bus.out_step_err = r_out_step_err;
  assign bus.out_wrap     = r_out_wrap;
  assign bus.err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_gray_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_stream_decoder
// Purpose  : Self-checking bench for gray_stream_decoder (WIDTH=4,
//            ERR_CNT_W=2): directed vector table, asynchronous reset
//            sequence, and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_stream_decoder;

  localparam int W    = 4;
  localparam int EW   = 2;
  localparam int CMAX = (1 << EW) - 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  gray_stream_decoder_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

  gray_stream_decoder #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (what the output stage should hold)
  bit m_valid;
  int m_bin;
  bit m_err;
  bit m_wrap;
  int m_cnt;
  int m_prev;
  bit m_has;

  function automatic int gray2bin(int g);
    int b = 0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b & ((1 << W) - 1);
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_bin = 0; m_err = 0; m_wrap = 0;
    m_cnt = 0; m_prev = 0; m_has = 0;
  endtask

  // One cycle: drive at negedge, check in_ready, clock, check outputs.
  task automatic step(bit v, int g, bit r, bit c);
    bit acc;
    bit chk;
    int d;
    bus.in_valid   = v;
    bus.in_gray    = g[W-1:0];
    bus.out_ready  = r;
    bus.clear_errs = c;
    #1;
    check("in_ready", int'(bus.in_ready), int'(!m_valid || r));
    acc = v && (!m_valid || r);
    if (acc) begin
      chk     = m_has && !c;
      d       = g ^ m_prev;
      m_err   = chk && ($countones(d[W-1:0]) != 1);
      m_wrap  = chk && (g == 0) && (m_prev == (1 << (W-1)));
      m_bin   = gray2bin(g);
      m_valid = 1;
      if (m_err && m_cnt < CMAX) m_cnt++;
      m_prev  = g;
      m_has   = 1;
    end else if (r) begin
      m_valid = 0;
    end
    if (c) begin
      m_cnt = 0;
      if (!acc) m_has = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", int'(bus.out_valid), int'(m_valid));
    check("err_count", int'(bus.err_count), m_cnt);
    if (m_valid) begin
      check("out_binary", int'(bus.out_binary), m_bin);
      check("out_step_err", int'(bus.out_step_err), int'(m_err));
      check("out_wrap", int'(bus.out_wrap), int'(m_wrap));
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit v; int g; bit r; bit c;
    bit ev; int eb; bit ee; bit ew; int ec;
  } vec_t;

  vec_t vecs[$];
  int   gseq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  function automatic vec_t mk(bit v, int g, bit r, bit c,
                              bit ev, int eb, bit ee, bit ew, int ec);
    vec_t t;
    t.v = v; t.g = g; t.r = r; t.c = c;
    t.ev = ev; t.eb = eb; t.ee = ee; t.ew = ew; t.ec = ec;
    return t;
  endfunction

  initial begin
    int last_g;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_gray = '0; bus.out_ready = 0; bus.clear_errs = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_err_count", int'(bus.err_count), 0);
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_binary", int'(bus.out_binary), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full count, wrap, step errors with saturation, clear, backpressure.
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, gseq[i], 1, 0, 1, i, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0001, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0010, 1, 0, 1, 3, 1, 0, 1));
    vecs.push_back(mk(1, 4'b0010, 1, 0, 1, 3, 1, 0, 2));
    vecs.push_back(mk(1, 4'b0010, 1, 0, 1, 3, 1, 0, 3));
    vecs.push_back(mk(1, 4'b0010, 1, 0, 1, 3, 1, 0, 3));
    vecs.push_back(mk(1, 4'b0010, 1, 0, 1, 3, 1, 0, 3));
    vecs.push_back(mk(1, 4'b0111, 1, 1, 1, 5, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0101, 1, 0, 1, 6, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 0, 1, 6, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 0, 1, 6, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1001, 0, 0, 1, 6, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 1, 0, 1, 7, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1100, 0, 0, 1, 8, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 8, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].g, vecs[i].r, vecs[i].c);
      check($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(vecs[i].ev));
      check($sformatf("vec%0d_count", i), int'(bus.err_count), vecs[i].ec);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_binary", i), int'(bus.out_binary), vecs[i].eb);
        check($sformatf("vec%0d_step_err", i), int'(bus.out_step_err), int'(vecs[i].ee));
        check($sformatf("vec%0d_wrap", i), int'(bus.out_wrap), int'(vecs[i].ew));
      end
    end

    // Mid-stream asynchronous reset with a pending sample and nonzero count.
    step(1, 4'b0011, 1, 0);
    step(1, 4'b0011, 0, 0);
    check("pre_rst_count", int'(bus.err_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", int'(bus.out_valid), 0);
    check("async_rst_err_count", int'(bus.err_count), 0);
    check("async_rst_in_ready", int'(bus.in_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // Two-bit jump from the reset history: first sample is unchecked.
    step(1, 4'b0110, 1, 0);
    check("post_rst_first_err", int'(bus.out_step_err), 0);
    check("post_rst_binary", int'(bus.out_binary), 4);

    // Randomized traffic against the model.
    last_g = 6;
    for (int n = 0; n < 600; n++) begin
      int g;
      if ($urandom_range(3) != 0) g = last_g ^ (1 << $urandom_range(W-1));
      else                        g = int'($urandom_range((1 << W) - 1));
      if (($urandom_range(7) == 0)) g = last_g;
      step($urandom_range(3) != 0, g, $urandom_range(2) != 0,
           $urandom_range(15) == 0);
      if (bus.in_valid && bus.in_gray == g[W-1:0]) last_g = g;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_stream_decoder.md
Name: gray_stream_decoder

Overview:
- Downstream consumer of the binary_to_gray stage.
- Accepts a stream of WIDTH-bit Gray codes over a valid/ready handshake and converts each one back to binary through a one-entry registered output stage.
- Checks that each code differs from the previously accepted code in exactly one bit, and keeps a saturating count of violations.
- Used in the converter datapath as a round-trip decoder and sequence monitor.

Parameters:
WIDTH, 4, bit width of Gray input and binary output (>=2)
ERR_CNT_W, 8, width of the saturating step-error counter

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  upstream presents in_gray
in_ready  output  1  block can accept this cycle
in_gray  input  WIDTH  Gray code from upstream
out_valid  output  1  out_* fields hold a decoded sample
out_ready  input  1  downstream accepts the output sample
out_binary  output  WIDTH  decoded binary value
out_step_err  output  1  sample violated the single-bit-change rule
out_wrap  output  1  sample is binary 0 and previous binary was all ones
err_count  output  ERR_CNT_W  saturating count of step errors
clear_errs  input  1  synchronous clear of err_count and sequence history

Behaviour:
- Reset (rst_n=0, asynchronous): clears all state immediately.
  - out_valid=0, out_binary=0, out_step_err=0, out_wrap=0, err_count=0.
  - has_prev=0, prev_gray=0.
- Accept rule: accept = in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - A full stage drains and refills in the same cycle; the stage sustains 1 sample/cycle.
- Decode on accept, registered:
  - b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0.
  - Latency: exactly 1 cycle from accept edge to out_valid=1.
- Step check on accept, when has_prev=1:
  - d = in_gray ^ prev_gray.
  - out_step_err <= (popcount(d) != 1). Identical codes (d=0) and multi-bit changes are both errors.
- No check on accept when has_prev=0 (first sample after reset or clear): out_step_err <= 0.
- Wrap flag: out_wrap <= has_prev && (in_gray == 0) && (prev_gray == {1'b1, {WIDTH-1{1'b0}}}), i.e. binary all-ones to 0.
- History update on every accept: prev_gray <= in_gray; has_prev <= 1.
- Output hold: while out_valid=1 && out_ready=0, out_binary, out_step_err and out_wrap are stable, and in_gray is ignored.
- Output release: out_valid clears on out_ready=1 unless a new accept occurs in the same cycle. In that case out_valid stays 1 and the fields update.
- err_count increments on each accept that sets out_step_err. It saturates at 2^ERR_CNT_W-1 and never wraps.
- clear_errs=1 in a cycle:
  - err_count <= 0; has_prev <= 0.
  - If an accept occurs in the same cycle, that sample is treated as first: no step check, no count, no wrap, and it loads prev_gray with has_prev <= 1.
  - The output register and handshake are unaffected by clear_errs.
- Reset mid-stream: a pending output sample is dropped (out_valid=0 asynchronously) and no handshake completes. After release, the next accepted sample is unchecked.
- in_gray is sampled only on accept. in_valid=1 while in_ready=0 has no effect.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out_valid=0, err_count=0, in_ready=1 without waiting for a clock edge.
- Full sequence, out_ready=1: in_valid=1 every cycle with Gray 0000,0001,0011,0010,0110,...,1000 (16 codes) -> out_binary 0..15, each one cycle after its accept, out_step_err=0 throughout, err_count=0.
- Wrap: accept 1000 then 0000 -> second sample out_binary=0000, out_wrap=1, out_step_err=0.
- Errors: accept 0001, 0010, 0010 -> second and third samples out_step_err=1, err_count=2.
- Saturation with ERR_CNT_W=2: five consecutive erroneous samples -> err_count sequence 1,2,3,3,3.
- Clear: clear_errs=1 with accept of 0111 -> err_count=0, out_step_err=0; next 0101 -> no error.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles, in_gray toggling -> in_ready=0, out_binary unchanged.
  - Raise out_ready with in_valid=1 -> sample replaced in the same cycle with no bubble.
  - Sequence history continues from the last accepted code.
